// File: rtl/psum_pkg.sv
// Shared types and helpers for the partial-sum scratchpad.
// Holds the clear-sweep FSM states and the signed saturation bounds for a given width.
package psum_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    // Bounds of a signed two's-complement word; valid for widths up to 31.
    function automatic int satMax(input int width);
        return (1 << (width - 1)) - 1;
    endfunction

    function automatic int satMin(input int width);
        return -(1 << (width - 1));
    endfunction

endpackage

// File: rtl/sat_add.sv
// Combinational signed adder whose result is clamped to the representable range.
// The sum is formed one bit wider so that overflow shows up as a sign disagreement.
module sat_add
    import psum_pkg::*;
#(
    parameter int DATA_BITWIDTH = 16
) (
    input  logic [DATA_BITWIDTH-1:0] i_a,
    input  logic [DATA_BITWIDTH-1:0] i_b,
    output logic [DATA_BITWIDTH-1:0] o_sum
);

    localparam logic [DATA_BITWIDTH-1:0] MAXV = DATA_BITWIDTH'(satMax(DATA_BITWIDTH));
    localparam logic [DATA_BITWIDTH-1:0] MINV = DATA_BITWIDTH'(satMin(DATA_BITWIDTH));

    logic [DATA_BITWIDTH:0] w_sum;

    assign w_sum = {i_a[DATA_BITWIDTH-1], i_a} + {i_b[DATA_BITWIDTH-1], i_b};

    always_comb begin
        o_sum = w_sum[DATA_BITWIDTH-1:0];
        if (w_sum[DATA_BITWIDTH] != w_sum[DATA_BITWIDTH-1]) begin
            o_sum = w_sum[DATA_BITWIDTH] ? MINV : MAXV;
        end
    end

endmodule

// File: rtl/psum_spad.sv
// Multi-read-port partial-sum scratchpad with write-first registered reads,
// saturating accumulate writes and a one-entry-per-cycle clear sweep.
module psum_spad
    import psum_pkg::*;
#(
    parameter int DATA_BITWIDTH = 16,
    parameter int ADDR_BITWIDTH = 4,
    parameter int NUM_RD        = 2
) (
    input  logic                              i_clk,
    input  logic                              i_rst,
    input  logic [NUM_RD*ADDR_BITWIDTH-1:0]   i_ra,
    output logic [NUM_RD*DATA_BITWIDTH-1:0]   o_rd,
    input  logic                              i_we,
    input  logic                              i_acc,
    input  logic [ADDR_BITWIDTH-1:0]          i_wa,
    input  logic [DATA_BITWIDTH-1:0]          i_wd,
    input  logic                              i_clr,
    output logic                              o_busy
);

    localparam int REG_COUNT = 2 ** ADDR_BITWIDTH;
    localparam logic [ADDR_BITWIDTH-1:0] LAST_ADDR = ADDR_BITWIDTH'(REG_COUNT - 1);

    state_t                   r_state;
    logic [ADDR_BITWIDTH-1:0] r_cnt;
    logic                     r_busy;
    logic [DATA_BITWIDTH-1:0] r_mem [REG_COUNT];

    logic                     w_clearing;
    logic                     w_wrEn;
    logic [DATA_BITWIDTH-1:0] w_satSum;
    logic [DATA_BITWIDTH-1:0] w_wrData;

    // Writes are only accepted in IDLE and lose to a same-cycle clear request.
    assign w_clearing = (r_state == CLEAR);
    assign w_wrEn     = i_we && (r_state == IDLE) && !i_clr;
    assign w_wrData   = i_acc ? w_satSum : i_wd;
    assign o_busy     = r_busy;

    sat_add #(
        .DATA_BITWIDTH(DATA_BITWIDTH)
    ) u_satAdd (
        .i_a   (r_mem[i_wa]),
        .i_b   (i_wd),
        .o_sum (w_satSum)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_clr) begin
                        r_state <= CLEAR;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                CLEAR: begin
                    r_cnt <= r_cnt + ADDR_BITWIDTH'(1);
                    if (r_cnt == LAST_ADDR) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_clearing) begin
            r_mem[r_cnt] <= '0;
        end else if (w_wrEn) begin
            r_mem[i_wa] <= w_wrData;
        end
    end

    // Each port returns whatever its entry holds after this edge's update.
    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_BITWIDTH-1:0] w_ra;
        logic [DATA_BITWIDTH-1:0] r_rdPort;

        assign w_ra = i_ra[k*ADDR_BITWIDTH +: ADDR_BITWIDTH];
        assign o_rd[k*DATA_BITWIDTH +: DATA_BITWIDTH] = r_rdPort;

        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                r_rdPort <= '0;
            end else if (w_wrEn && (i_wa == w_ra)) begin
                r_rdPort <= w_wrData;
            end else if (w_clearing && (r_cnt == w_ra)) begin
                r_rdPort <= '0;
            end else begin
                r_rdPort <= r_mem[w_ra];
            end
        end
    end

endmodule

// File: tb/tb_psum_spad.sv
// Directed self-checking bench for psum_spad: reset, forwarding, accumulate,
// saturation, clear sweep and reset during a sweep.
module tb_psum_spad;

    localparam int DW = 16;
    localparam int AW = 4;
    localparam int NR = 2;

    logic             i_clk;
    logic             i_rst;
    logic [NR*AW-1:0] i_ra;
    logic [NR*DW-1:0] o_rd;
    logic             i_we;
    logic             i_acc;
    logic [AW-1:0]    i_wa;
    logic [DW-1:0]    i_wd;
    logic             i_clr;
    logic             o_busy;

    int nChecks = 0;
    int nFails  = 0;

    psum_spad #(
        .DATA_BITWIDTH(DW),
        .ADDR_BITWIDTH(AW),
        .NUM_RD       (NR)
    ) dut (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_ra   (i_ra),
        .o_rd   (o_rd),
        .i_we   (i_we),
        .i_acc  (i_acc),
        .i_wa   (i_wa),
        .i_wd   (i_wd),
        .i_clr  (i_clr),
        .o_busy (o_busy)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Inputs change 1ns after a rising edge; outputs are sampled at the same point.
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    function automatic logic [DW-1:0] fillVal(input int a);
        return DW'(a * 16'h0101 + 16'h0011);
    endfunction

    function automatic logic [DW-1:0] rd0();
        return o_rd[DW-1:0];
    endfunction

    function automatic logic [DW-1:0] rd1();
        return o_rd[2*DW-1:DW];
    endfunction

    task automatic setRead(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        i_ra = {a1, a0};
    endtask

    task automatic writeWord(input logic [AW-1:0] a, input logic [DW-1:0] d);
        i_we = 1'b1; i_acc = 1'b0; i_wa = a; i_wd = d;
        tick();
        i_we = 1'b0;
    endtask

    task automatic fillAll();
        for (int a = 0; a < 16; a++) writeWord(AW'(a), fillVal(a));
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        tick();
        tick();
        i_rst = 1'b0;
        nChecks++;
        if (o_busy !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL reset_busy: got %b expected 0", o_busy);
        end
        nChecks++;
        if (o_rd !== '0) begin
            nFails++;
            $display("[TB] FAIL reset_rd: got %h expected 0", o_rd);
        end
        for (int a = 0; a < 16; a++) begin
            setRead(AW'(a), AW'(15 - a));
            tick();
            nChecks++;
            if (rd0() !== 16'h0 || rd1() !== 16'h0) begin
                nFails++;
                $display("[TB] FAIL reset_read addr %0d: got %h/%h expected 0/0", a, rd0(), rd1());
            end
            nChecks++;
            if (o_busy !== 1'b0) begin
                nFails++;
                $display("[TB] FAIL reset_busy_idle: got %b expected 0", o_busy);
            end
        end
    endtask

    task automatic test_overwrite_forward();
        setRead(4'd3, 4'd4);
        i_we = 1'b1; i_acc = 1'b0; i_wa = 4'd3; i_wd = 16'h1234;
        tick();
        i_we = 1'b0;
        nChecks++;
        if (rd0() !== 16'h1234) begin
            nFails++;
            $display("[TB] FAIL fwd_overwrite: got %h expected 1234", rd0());
        end
        nChecks++;
        if (rd1() !== 16'h0000) begin
            nFails++;
            $display("[TB] FAIL fwd_other_port: got %h expected 0000", rd1());
        end
        setRead(4'd4, 4'd3);
        tick();
        nChecks++;
        if (rd1() !== 16'h1234 || rd0() !== 16'h0000) begin
            nFails++;
            $display("[TB] FAIL overwrite_direct: got %h/%h expected 0000/1234", rd0(), rd1());
        end
    endtask

    task automatic test_accumulate();
        logic [DW-1:0] expSeq [3];
        expSeq[0] = 16'h0015;
        expSeq[1] = 16'h001A;
        expSeq[2] = 16'h001F;
        writeWord(4'd5, 16'h0010);
        setRead(4'd5, 4'd5);
        i_we = 1'b1; i_acc = 1'b1; i_wa = 4'd5; i_wd = 16'h0005;
        for (int i = 0; i < 3; i++) begin
            tick();
            nChecks++;
            if (rd0() !== expSeq[i] || rd1() !== expSeq[i]) begin
                nFails++;
                $display("[TB] FAIL acc_step%0d: got %h/%h expected %h", i, rd0(), rd1(), expSeq[i]);
            end
        end
        i_we = 1'b0; i_acc = 1'b0;
        tick();
        nChecks++;
        if (rd0() !== 16'h001F) begin
            nFails++;
            $display("[TB] FAIL acc_hold: got %h expected 001F", rd0());
        end
    endtask

    task automatic test_saturation();
        writeWord(4'd7, 16'h7FF0);
        writeWord(4'd8, 16'h8010);
        setRead(4'd7, 4'd8);
        i_we = 1'b1; i_acc = 1'b1; i_wa = 4'd7; i_wd = 16'h0100;
        tick();
        nChecks++;
        if (rd0() !== 16'h7FFF) begin
            nFails++;
            $display("[TB] FAIL sat_pos: got %h expected 7FFF", rd0());
        end
        i_wa = 4'd8; i_wd = 16'hFF00;
        tick();
        nChecks++;
        if (rd1() !== 16'h8000) begin
            nFails++;
            $display("[TB] FAIL sat_neg: got %h expected 8000", rd1());
        end
        i_wa = 4'd8; i_wd = 16'h0100;
        tick();
        i_we = 1'b0; i_acc = 1'b0;
        nChecks++;
        if (rd1() !== 16'h8100 || rd0() !== 16'h7FFF) begin
            nFails++;
            $display("[TB] FAIL sat_recover: got %h/%h expected 7FFF/8100", rd0(), rd1());
        end
    endtask

    task automatic test_clear();
        int busyCount;
        fillAll();
        setRead(4'd2, 4'd15);
        i_clr = 1'b1;
        i_we = 1'b1; i_acc = 1'b0; i_wa = 4'd2; i_wd = 16'hBEEF;
        tick();
        i_clr = 1'b0; i_we = 1'b0;
        busyCount = (o_busy === 1'b1) ? 1 : 0;
        nChecks++;
        if (rd0() !== fillVal(2)) begin
            nFails++;
            $display("[TB] FAIL clr_write_dropped: got %h expected %h", rd0(), fillVal(2));
        end
        nChecks++;
        if (o_busy !== 1'b1) begin
            nFails++;
            $display("[TB] FAIL clr_busy_rise: got %b expected 1", o_busy);
        end
        for (int j = 0; j < 16; j++) begin
            setRead(AW'(j), 4'd15);
            i_clr = (j == 5);
            tick();
            i_clr = 1'b0;
            if (o_busy === 1'b1) busyCount++;
            nChecks++;
            if (rd0() !== 16'h0 || rd1() !== ((j == 15) ? 16'h0 : fillVal(15))) begin
                nFails++;
                $display("[TB] FAIL clr_sweep j=%0d: got %h/%h expected 0000/%h", j, rd0(), rd1(),
                         (j == 15) ? 16'h0 : fillVal(15));
            end
            nChecks++;
            if (o_busy !== (j < 15)) begin
                nFails++;
                $display("[TB] FAIL clr_busy j=%0d: got %b expected %b", j, o_busy, (j < 15));
            end
        end
        nChecks++;
        if (busyCount != 16) begin
            nFails++;
            $display("[TB] FAIL clr_busy_len: got %0d expected 16", busyCount);
        end
        for (int a = 0; a < 16; a++) begin
            setRead(AW'(a), AW'(a));
            tick();
            nChecks++;
            if (rd0() !== 16'h0 || rd1() !== 16'h0 || o_busy !== 1'b0) begin
                nFails++;
                $display("[TB] FAIL clr_after addr %0d: got %h/%h busy %b expected 0/0 busy 0",
                         a, rd0(), rd1(), o_busy);
            end
        end
    endtask

    task automatic test_reset_mid_sweep();
        fillAll();
        i_clr = 1'b1;
        tick();
        i_clr = 1'b0;
        for (int j = 0; j < 6; j++) tick();
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        nChecks++;
        if (o_busy !== 1'b0 || o_rd !== '0) begin
            nFails++;
            $display("[TB] FAIL rst_sweep: got busy %b rd %h expected 0/0", o_busy, o_rd);
        end
        for (int a = 0; a < 16; a++) begin
            setRead(AW'(a), AW'(a));
            tick();
            nChecks++;
            if (rd0() !== 16'h0 || rd1() !== 16'h0 || o_busy !== 1'b0) begin
                nFails++;
                $display("[TB] FAIL rst_sweep_entry %0d: got %h/%h busy %b expected 0/0 busy 0",
                         a, rd0(), rd1(), o_busy);
            end
        end
        writeWord(4'd9, 16'h0ABC);
        setRead(4'd9, 4'd9);
        tick();
        nChecks++;
        if (rd0() !== 16'h0ABC || rd1() !== 16'h0ABC) begin
            nFails++;
            $display("[TB] FAIL rst_post_write: got %h/%h expected 0ABC", rd0(), rd1());
        end
    endtask

    initial begin
        i_rst = 1'b0; i_ra = '0; i_we = 1'b0; i_acc = 1'b0;
        i_wa = '0; i_wd = '0; i_clr = 1'b0;
        #1;
        test_reset();
        test_overwrite_forward();
        test_accumulate();
        test_saturation();
        test_clear();
        test_reset_mid_sweep();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
